// File: rtl/prim_subreg_pkg.sv
// Shared types for the subregister primitives and the staged subregister bank.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessW1C = 3'd2,
        SwAccessW1S = 3'd3,
        SwAccessW0C = 3'd4
    } sw_access_e;

    typedef enum logic {
        BankIdle = 1'b0,
        BankPend = 1'b1
    } bank_state_e;

endpackage

// File: rtl/prim_subreg_bank_ch.sv
// One channel of the staged subregister bank: staging buffer, pending bit,
// access-mode merge/apply logic and the committed value with its update pulse.
module prim_subreg_bank_ch
    import prim_subreg_pkg::*;
#(
    parameter int unsigned    DW       = 32,
    parameter sw_access_e     SwAccess = SwAccessRW,
    parameter logic [DW-1:0]  RESVAL   = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          we_i,
    input  logic [DW-1:0] wd_i,
    input  logic          commit_i,
    input  logic          discard_i,
    input  logic          hw_de_i,
    input  logic [DW-1:0] hw_d_i,
    output logic [DW-1:0] q_o,
    output logic          qe_o,
    output logic          pend_o
);

    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] stage_q, stage_d;
    logic          pend_q, pend_d;
    logic          qe_q, qe_d;

    logic          we_acc_s;
    logic          mask_eff_s;
    logic [DW-1:0] stage_init_s;
    logic [DW-1:0] stage_merge_s;
    logic [DW-1:0] stage_eff_s;
    logic [DW-1:0] base_s;
    logic [DW-1:0] commit_val_s;

    // Staged value including a same-cycle write, and the value a commit would produce.
    always_comb begin
        we_acc_s = we_i && (SwAccess != SwAccessRO);

        // A fresh W0C stage starts from all-ones so that only written zeros clear.
        if (pend_q) begin
            stage_init_s = stage_q;
        end else if (SwAccess == SwAccessW0C) begin
            stage_init_s = {DW{1'b1}};
        end else begin
            stage_init_s = {DW{1'b0}};
        end

        case (SwAccess)
            SwAccessRW:  stage_merge_s = wd_i;
            SwAccessW1C: stage_merge_s = stage_init_s | wd_i;
            SwAccessW1S: stage_merge_s = stage_init_s | wd_i;
            SwAccessW0C: stage_merge_s = stage_init_s & wd_i;
            default:     stage_merge_s = stage_init_s;
        endcase

        stage_eff_s = we_acc_s ? stage_merge_s : stage_q;
        mask_eff_s  = pend_q || we_acc_s;
        base_s      = hw_de_i ? hw_d_i : q_q;

        case (SwAccess)
            SwAccessRW:  commit_val_s = stage_eff_s;
            SwAccessW1C: commit_val_s = base_s & ~stage_eff_s;
            SwAccessW1S: commit_val_s = base_s | stage_eff_s;
            SwAccessW0C: commit_val_s = base_s & stage_eff_s;
            default:     commit_val_s = base_s;
        endcase
    end

    // Next-state selection: discard beats commit, commit beats plain hardware data.
    always_comb begin
        q_d     = q_q;
        stage_d = stage_q;
        pend_d  = pend_q;
        qe_d    = 1'b0;
        if (discard_i) begin
            stage_d = {DW{1'b0}};
            pend_d  = 1'b0;
            if (hw_de_i) begin
                q_d = hw_d_i;
            end else begin
                q_d = q_q;
            end
        end else if (commit_i && mask_eff_s) begin
            q_d     = commit_val_s;
            qe_d    = 1'b1;
            stage_d = {DW{1'b0}};
            pend_d  = 1'b0;
        end else begin
            if (hw_de_i) begin
                q_d = hw_d_i;
            end else begin
                q_d = q_q;
            end
            if (we_acc_s) begin
                stage_d = stage_eff_s;
                pend_d  = 1'b1;
            end else begin
                stage_d = stage_q;
                pend_d  = pend_q;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q     <= RESVAL;
            stage_q <= {DW{1'b0}};
            pend_q  <= 1'b0;
            qe_q    <= 1'b0;
        end else begin
            q_q     <= q_d;
            stage_q <= stage_d;
            pend_q  <= pend_d;
            qe_q    <= qe_d;
        end
    end

    assign q_o    = q_q;
    assign qe_o   = qe_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/prim_subreg_bank.sv
// Bank of NumCh subregisters with staged, atomic multi-channel commit.
// Optional staging timeout is enabled by defining PRIM_SUBREG_BANK_TIMEOUT_EN.
module prim_subreg_bank
    import prim_subreg_pkg::*;
#(
    parameter int unsigned   DW            = 32,
    parameter int unsigned   NumCh         = 4,
    parameter sw_access_e    SwAccess      = SwAccessRW,
    parameter logic [DW-1:0] RESVAL        = '0,
    parameter int unsigned   TimeoutCycles = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NumCh-1:0]    sw_we_i,
    input  logic [DW-1:0]       sw_wd_i,
    input  logic                sw_commit_i,
    input  logic                sw_abort_i,
    input  logic [NumCh-1:0]    hw_de_i,
    input  logic [NumCh*DW-1:0] hw_d_i,
    output logic [NumCh*DW-1:0] sw_qs_o,
    output logic [NumCh-1:0]    sw_pend_o,
    output logic                busy_o,
    output logic [NumCh-1:0]    hw_qe_o,
    output logic [NumCh*DW-1:0] q_o,
    output logic                err_o
);

    bank_state_e state_q, state_d;
    logic        busy_q, busy_d;
    logic        any_we_s;
    logic        timeout_s;
    logic        discard_s;

    logic [NumCh*DW-1:0] q_s;

    assign any_we_s  = (|sw_we_i) && (SwAccess != SwAccessRO);
    assign discard_s = sw_abort_i || timeout_s;

`ifdef PRIM_SUBREG_BANK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Staging timeout: a commit in the expiry cycle still wins.
    always_comb begin
        timeout_s = (state_q == BankPend) && (cnt_q == CntW'(TimeoutCycles)) && !sw_commit_i;
        err_d     = timeout_s;
        if ((state_q == BankPend) && !timeout_s && !sw_commit_i && !sw_abort_i) begin
            if (any_we_s) begin
                cnt_d = {CntW{1'b0}};
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = {CntW{1'b0}};
        end
    end

    // Timeout counter and error pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= {CntW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
    assign timeout_s      = 1'b0;
    assign err_o          = 1'b0;
`endif

    // FSM next state: PEND exactly while some channel holds staged data.
    always_comb begin
        case (state_q)
            BankIdle: begin
                if (any_we_s && !sw_commit_i && !sw_abort_i) begin
                    state_d = BankPend;
                end else begin
                    state_d = BankIdle;
                end
            end
            BankPend: begin
                if (sw_commit_i || discard_s) begin
                    state_d = BankIdle;
                end else begin
                    state_d = BankPend;
                end
            end
            default: state_d = BankIdle;
        endcase
        busy_d = (state_d == BankPend);
    end

    // FSM state and registered busy flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= BankIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar k = 0; k < NumCh; k++) begin : g_ch
        prim_subreg_bank_ch #(
            .DW       (DW),
            .SwAccess (SwAccess),
            .RESVAL   (RESVAL)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .we_i      (sw_we_i[k]),
            .wd_i      (sw_wd_i),
            .commit_i  (sw_commit_i),
            .discard_i (discard_s),
            .hw_de_i   (hw_de_i[k]),
            .hw_d_i    (hw_d_i[k*DW +: DW]),
            .q_o       (q_s[k*DW +: DW]),
            .qe_o      (hw_qe_o[k]),
            .pend_o    (sw_pend_o[k])
        );
    end

    assign busy_o  = busy_q;
    assign sw_qs_o = q_s;
    assign q_o     = q_s;

endmodule

// File: tb/tb_prim_subreg_bank.sv
// Self-checking bench: one bank per access mode, all driven by shared stimulus.
module tb_prim_subreg_bank;
    import prim_subreg_pkg::*;

    localparam int          NM     = 5;
    localparam int          TO     = 4;
    localparam logic [31:0] RESVAL = 32'hA5A5_0000;
`ifdef PRIM_SUBREG_BANK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   sw_we;
    logic [31:0]  sw_wd;
    logic         sw_commit;
    logic         sw_abort;
    logic [3:0]   hw_de;
    logic [127:0] hw_d;

    logic [127:0] qs_w   [NM];
    logic [127:0] q_w    [NM];
    logic [3:0]   pend_w [NM];
    logic [3:0]   qe_w   [NM];
    logic         busy_w [NM];
    logic         err_w  [NM];

    int checks = 0;
    int errors = 0;

    // Reference model state per mode and channel.
    logic [31:0] mq    [NM][4];
    logic [31:0] mstg  [NM][4];
    logic        mpend [NM][4];
    logic        mqe   [NM][4];
    logic        merr  [NM];
    int          mcnt  [NM];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        prim_subreg_bank #(
            .DW(32), .NumCh(4), .SwAccess(sw_access_e'(g)), .RESVAL(RESVAL), .TimeoutCycles(TO)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .sw_we_i(sw_we), .sw_wd_i(sw_wd),
            .sw_commit_i(sw_commit), .sw_abort_i(sw_abort), .hw_de_i(hw_de), .hw_d_i(hw_d),
            .sw_qs_o(qs_w[g]), .sw_pend_o(pend_w[g]), .busy_o(busy_w[g]), .hw_qe_o(qe_w[g]),
            .q_o(q_w[g]), .err_o(err_w[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sw_we = 4'b0; sw_wd = 32'h0; sw_commit = 1'b0; sw_abort = 1'b0;
        hw_de = 4'b0; hw_d = 128'h0;
    endtask

    // Staged value after a software write, from the mode's rule.
    function automatic logic [31:0] model_merge(int m, logic pend, logic [31:0] old, logic [31:0] wd);
        logic [31:0] start;
        start = pend ? old : ((m == 4) ? 32'hFFFF_FFFF : 32'h0);
        case (m)
            0:       return wd;
            2, 3:    return start | wd;
            4:       return start & wd;
            default: return old;
        endcase
    endfunction

    // Committed value from base and staged value, from the mode's rule.
    function automatic logic [31:0] model_apply(int m, logic [31:0] base, logic [31:0] st);
        case (m)
            0:       return st;
            2:       return base & ~st;
            3:       return base | st;
            4:       return base & st;
            default: return base;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int k = 0; k < 4; k++) begin
                mq[m][k] = RESVAL; mstg[m][k] = 32'h0; mpend[m][k] = 1'b0; mqe[m][k] = 1'b0;
            end
            merr[m] = 1'b0; mcnt[m] = 0;
        end
    endtask

    // Advance the model by one cycle using the currently driven inputs.
    task automatic model_step();
        for (int m = 0; m < NM; m++) begin
            logic any_pend, any_acc, tmo, still;
            any_pend = 1'b0; any_acc = 1'b0; still = 1'b0;
            for (int k = 0; k < 4; k++) any_pend |= mpend[m][k];
            tmo = TO_EN && any_pend && (mcnt[m] == TO) && !sw_commit;
            for (int k = 0; k < 4; k++) begin
                logic        acc, pe;
                logic [31:0] st, base, hdk;
                hdk  = hw_d[k*32 +: 32];
                acc  = sw_we[k] && (m != 1);
                pe   = mpend[m][k] || acc;
                st   = acc ? model_merge(m, mpend[m][k], mstg[m][k], sw_wd) : mstg[m][k];
                base = hw_de[k] ? hdk : mq[m][k];
                mqe[m][k] = 1'b0;
                if (sw_abort || tmo) begin
                    mpend[m][k] = 1'b0;
                    if (hw_de[k]) mq[m][k] = hdk;
                end else if (sw_commit && pe) begin
                    mq[m][k] = model_apply(m, base, st);
                    mqe[m][k] = 1'b1;
                    mpend[m][k] = 1'b0;
                end else begin
                    if (hw_de[k]) mq[m][k] = hdk;
                    if (acc) begin
                        mpend[m][k] = 1'b1; mstg[m][k] = st; any_acc = 1'b1;
                    end
                end
                still |= mpend[m][k];
            end
            merr[m] = tmo;
            if (!still || any_acc) mcnt[m] = 0;
            else mcnt[m] = mcnt[m] + 1;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int m = 0; m < NM; m++) begin
            checks += 5;
            if (q_w[m] !== {4{RESVAL}} || qs_w[m] !== {4{RESVAL}}) begin
                errors++; $display("FAIL reset_q mode=%0d got=%h want=%h", m, q_w[m], {4{RESVAL}});
            end
            if (busy_w[m] !== 1'b0) begin errors++; $display("FAIL reset_busy mode=%0d got=%b want=0", m, busy_w[m]); end
            if (qe_w[m] !== 4'b0) begin errors++; $display("FAIL reset_qe mode=%0d got=%b want=0000", m, qe_w[m]); end
            if (pend_w[m] !== 4'b0) begin errors++; $display("FAIL reset_pend mode=%0d got=%b want=0000", m, pend_w[m]); end
            if (err_w[m] !== 1'b0) begin errors++; $display("FAIL reset_err mode=%0d got=%b want=0", m, err_w[m]); end
        end
    endtask

    task automatic test_rw();
        sw_we = 4'b0001; sw_wd = 32'h1; tick();
        checks += 2;
        if (pend_w[0] !== 4'b0001) begin errors++; $display("FAIL rw_pend got=%b want=0001", pend_w[0]); end
        if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL rw_busy got=%b want=1", busy_w[0]); end
        sw_we = 4'b0100; sw_wd = 32'h2; tick();
        sw_we = 4'b0; sw_commit = 1'b1; tick();
        sw_commit = 1'b0;
        checks += 3;
        if (q_w[0] !== {RESVAL, 32'h2, RESVAL, 32'h1}) begin
            errors++; $display("FAIL rw_q got=%h want=%h", q_w[0], {RESVAL, 32'h2, RESVAL, 32'h1});
        end
        if (qe_w[0] !== 4'b0101) begin errors++; $display("FAIL rw_qe got=%b want=0101", qe_w[0]); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rw_busy_after got=%b want=0", busy_w[0]); end
        tick();
        checks++;
        if (qe_w[0] !== 4'b0) begin errors++; $display("FAIL rw_qe_pulse got=%b want=0000", qe_w[0]); end
    endtask

    task automatic test_w1c();
        hw_de = 4'b0010; hw_d = 128'h0; hw_d[63:32] = 32'hFF; tick();
        hw_de = 4'b0;
        checks++;
        if (q_w[2][63:32] !== 32'hFF) begin errors++; $display("FAIL w1c_hwload got=%h want=000000ff", q_w[2][63:32]); end
        sw_we = 4'b0010; sw_wd = 32'h0F; tick();
        sw_wd = 32'hF0; tick();
        sw_we = 4'b0; sw_commit = 1'b1; hw_de = 4'b0010; hw_d[63:32] = 32'hFFFF; tick();
        sw_commit = 1'b0; hw_de = 4'b0;
        checks += 2;
        if (q_w[2][63:32] !== 32'hFF00) begin errors++; $display("FAIL w1c_q got=%h want=0000ff00", q_w[2][63:32]); end
        if (qe_w[2] !== 4'b0010) begin errors++; $display("FAIL w1c_qe got=%b want=0010", qe_w[2]); end
    endtask

    task automatic test_abort();
        sw_we = 4'b1000; sw_wd = 32'hDEAD_BEEF; tick();
        sw_we = 4'b0; sw_commit = 1'b1; sw_abort = 1'b1; tick();
        sw_commit = 1'b0; sw_abort = 1'b0;
        checks += 4;
        if (q_w[0][127:96] !== RESVAL) begin errors++; $display("FAIL abort_q got=%h want=%h", q_w[0][127:96], RESVAL); end
        if (qe_w[0] !== 4'b0) begin errors++; $display("FAIL abort_qe got=%b want=0000", qe_w[0]); end
        if (pend_w[0] !== 4'b0) begin errors++; $display("FAIL abort_pend got=%b want=0000", pend_w[0]); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy_w[0]); end
    endtask

    task automatic test_bypass();
        sw_we = 4'b0001; sw_wd = 32'h7; sw_commit = 1'b1; tick();
        sw_we = 4'b0; sw_commit = 1'b0;
        checks += 3;
        if (q_w[0][31:0] !== 32'h7) begin errors++; $display("FAIL bypass_q got=%h want=00000007", q_w[0][31:0]); end
        if (qe_w[0] !== 4'b0001) begin errors++; $display("FAIL bypass_qe got=%b want=0001", qe_w[0]); end
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL bypass_busy got=%b want=0", busy_w[0]); end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        sw_we = 4'b0001; sw_wd = 32'h55; tick();
        sw_we = 4'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (err_w[0] === 1'b1) pulses++;
        end
        checks += 3;
`ifdef PRIM_SUBREG_BANK_TIMEOUT_EN
        if (pulses != 1) begin errors++; $display("FAIL timeout_err pulses=%0d want=1", pulses); end
        if (pend_w[0] !== 4'b0) begin errors++; $display("FAIL timeout_pend got=%b want=0000", pend_w[0]); end
        if (q_w[0][31:0] !== 32'h7) begin errors++; $display("FAIL timeout_q got=%h want=00000007", q_w[0][31:0]); end
`else
        if (pulses != 0) begin errors++; $display("FAIL hold_err pulses=%0d want=0", pulses); end
        if (pend_w[0] !== 4'b0001) begin errors++; $display("FAIL hold_pend got=%b want=0001", pend_w[0]); end
        if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b want=1", busy_w[0]); end
`endif
        sw_abort = 1'b1; tick();
        sw_abort = 1'b0;
    endtask

    task automatic test_random();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            sw_we     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            sw_wd     = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
            sw_commit = ($urandom_range(0, 4) == 0);
            sw_abort  = ($urandom_range(0, 15) == 0);
            hw_de     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            hw_d      = {$urandom, $urandom, $urandom, $urandom};
            model_step();
            tick();
            for (int m = 0; m < NM; m++) begin
                logic [127:0] eq;
                logic [3:0]   ep, eqe;
                logic         eb;
                eb = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    eq[k*32 +: 32] = mq[m][k]; ep[k] = mpend[m][k]; eqe[k] = mqe[m][k];
                    eb |= mpend[m][k];
                end
                checks += 6;
                if (q_w[m] !== eq) begin errors++; if (errors < 40) $display("FAIL rnd_q c=%0d m=%0d got=%h want=%h", c, m, q_w[m], eq); end
                if (qs_w[m] !== eq) begin errors++; if (errors < 40) $display("FAIL rnd_qs c=%0d m=%0d got=%h want=%h", c, m, qs_w[m], eq); end
                if (pend_w[m] !== ep) begin errors++; if (errors < 40) $display("FAIL rnd_pend c=%0d m=%0d got=%b want=%b", c, m, pend_w[m], ep); end
                if (qe_w[m] !== eqe) begin errors++; if (errors < 40) $display("FAIL rnd_qe c=%0d m=%0d got=%b want=%b", c, m, qe_w[m], eqe); end
                if (busy_w[m] !== eb) begin errors++; if (errors < 40) $display("FAIL rnd_busy c=%0d m=%0d got=%b want=%b", c, m, busy_w[m], eb); end
                if (err_w[m] !== merr[m]) begin errors++; if (errors < 40) $display("FAIL rnd_err c=%0d m=%0d got=%b want=%b", c, m, err_w[m], merr[m]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_rw();
        test_w1c();
        test_abort();
        test_bypass();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
